// File: rtl/ram_arbiter.sv
// ram_arbiter: two-requester arbiter in front of a single-port synchronous RAM.
// Requester 0 is the CPU bus side, requester 1 the game/display engine.
// One transaction at a time: IDLE samples and latches the winner, ISSUE drives
// the RAM, and RDATA (reads only) captures the RAM output.
// Timing seen by a requester (cycle n = the IDLE cycle its request is sampled):
//   n+1 : ISSUE, ram_addr/ram_we/ram_data_in driven
//   n+2 : gnt pulse (registered out of ISSUE)
//   n+3 : rvalid pulse with m_rdata (reads only, registered out of RDATA)
// Optional build macro: RAM_ARB_CPU_PRIORITY_EN -- requester 0 wins every
// contention; otherwise contention is resolved round-robin via last_gnt.
module ram_arbiter #(
  parameter int unsigned AW = 10,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m_rdata,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_data_in,
  input  logic [DW-1:0] ram_data_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RDATA = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          id_q, id_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          last_gnt_q, last_gnt_d;
  logic [1:0]    gnt_q, gnt_d;
  logic [1:0]    rvalid_q, rvalid_d;
  logic [DW-1:0] rdata_q, rdata_d;

  logic          any_req;
  logic          win;

  // Winner selection, transaction latching and next-state decode
  always_comb begin
    any_req    = m0_req | m1_req;
    win        = 1'b0;
    state_d    = state_q;
    id_d       = id_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    last_gnt_d = last_gnt_q;
    gnt_d      = '0;
    rvalid_d   = '0;
    rdata_d    = rdata_q;

    if (m0_req && m1_req) begin
`ifdef RAM_ARB_CPU_PRIORITY_EN
      win = 1'b0;
`else
      win = ~last_gnt_q;
`endif
    end else begin
      win = m1_req;
    end

    case (state_q)
      IDLE: begin
        if (any_req) begin
          id_d    = win;
          we_d    = win ? m1_we    : m0_we;
          addr_d  = win ? m1_addr  : m0_addr;
          wdata_d = win ? m1_wdata : m0_wdata;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        gnt_d[id_q] = 1'b1;
        last_gnt_d  = id_q;
        state_d     = we_q ? IDLE : RDATA;
      end
      RDATA: begin
        rvalid_d[id_q] = 1'b1;
        rdata_d        = ram_data_out;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any transaction in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      id_q       <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      last_gnt_q <= 1'b1;
      gnt_q      <= '0;
      rvalid_q   <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      last_gnt_q <= last_gnt_d;
      gnt_q      <= gnt_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
    end
  end

  // RAM port is driven only in ISSUE and parked at zero otherwise
  always_comb begin
    ram_we      = (state_q == ISSUE) & we_q;
    ram_addr    = (state_q == ISSUE) ? addr_q  : '0;
    ram_data_in = (state_q == ISSUE) ? wdata_q : '0;
  end

  assign m0_gnt    = gnt_q[0];
  assign m1_gnt    = gnt_q[1];
  assign m0_rvalid = rvalid_q[0];
  assign m1_rvalid = rvalid_q[1];
  assign m_rdata   = rdata_q;

endmodule
